// File: rtl/hub_reg_bank_if.sv
// Host register bus for hub_reg_bank: one write port and one read port.
// Write strobe only, no backpressure: reg_wen high for one cycle moves one word, every cycle is accepted.
interface hub_reg_bank_if;
   logic        reg_wen;
   logic [15:0] reg_waddr;
   logic [31:0] reg_wdata;
   logic [15:0] reg_raddr;
   logic [31:0] reg_rdata;

   modport master (
      output reg_wen, reg_waddr, reg_wdata, reg_raddr,
      input  reg_rdata
   );

   modport slave (
      input  reg_wen, reg_waddr, reg_wdata, reg_raddr,
      output reg_rdata
   );
endinterface

// File: rtl/hub_reg_bank.sv
// Hub register bank: per-board word storage, per-board valid tracking, hub sequence counter,
// and a one-cycle registered host read port with read-during-write bypass.
module hub_reg_bank #(
   parameter logic [3:0] ADDR_SEL        = 4'h2,
   parameter int         NUM_BOARDS      = 16,
   parameter int         WORDS_PER_BOARD = 16,
   parameter int         DATA_W          = 32
) (
   input  logic                  sysclk,
   input  logic                  reset,
   hub_reg_bank_if.slave         bus,
   input  logic                  hub_start,
   output logic [NUM_BOARDS-1:0] valid_mask,
   output logic                  all_valid
);
   localparam int WW    = $clog2(WORDS_PER_BOARD);
   localparam int BW    = (NUM_BOARDS > 1) ? $clog2(NUM_BOARDS) : 1;
   localparam int AW    = WW + BW;
   localparam int DEPTH = NUM_BOARDS * WORDS_PER_BOARD;
   localparam logic [11:0] CTRL_MASK = 12'h800;
   localparam logic [11:0] CTRL_SEQ  = 12'h801;

   typedef enum logic [1:0] {SRC_ZERO, SRC_MEM, SRC_HOLD} rsrc_e;

   logic [DATA_W-1:0]     mem [DEPTH];
   logic [DATA_W-1:0]     mem_q;
   logic [DATA_W-1:0]     hold_q, hold_next;
   rsrc_e                 rsrc_q, rsrc_next;
   logic [15:0]           hub_seq;
   logic [NUM_BOARDS-1:0] mask_next;

   logic          w_sel, r_sel, w_in_range, r_in_range;
   logic          data_wr, clr_wr, completes;
   logic [BW-1:0] w_board, r_board;
   logic [WW-1:0] w_word;
   logic [AW-1:0] w_idx, r_idx;
   logic          unused_addr_bits;

   assign w_sel      = (bus.reg_waddr[15:12] == ADDR_SEL);
   assign r_sel      = (bus.reg_raddr[15:12] == ADDR_SEL);
   assign w_board    = bus.reg_waddr[AW-1:WW];
   assign r_board    = bus.reg_raddr[AW-1:WW];
   assign w_word     = bus.reg_waddr[WW-1:0];
   assign w_idx      = bus.reg_waddr[AW-1:0];
   assign r_idx      = bus.reg_raddr[AW-1:0];
   assign w_in_range = (32'(w_board) < NUM_BOARDS);
   assign r_in_range = (32'(r_board) < NUM_BOARDS);
   assign data_wr    = bus.reg_wen & w_sel & ~bus.reg_waddr[11] & w_in_range;
   assign clr_wr     = bus.reg_wen & w_sel & (bus.reg_waddr[11:0] == CTRL_MASK);
   assign completes  = data_wr & (w_word == WW'(WORDS_PER_BOARD - 1));
   assign unused_addr_bits = ^{bus.reg_waddr, bus.reg_raddr};

   // Storage has no reset so it maps onto block RAM; the read is synchronous.
   always_ff @(posedge sysclk) begin
      if (data_wr) mem[w_idx] <= bus.reg_wdata;
      mem_q <= mem[r_idx];
   end

   // hub_start clears first, so a board completing in the same cycle ends valid.
   always_comb begin
      mask_next = valid_mask;
      if (hub_start) mask_next = '0;
      if (clr_wr)    mask_next = mask_next & ~bus.reg_wdata[NUM_BOARDS-1:0];
      if (completes) mask_next[w_board] = 1'b1;
   end

   // Read source is chosen one cycle early; bypass and control words travel via hold_q.
   always_comb begin
      rsrc_next = SRC_ZERO;
      hold_next = '0;
      if (r_sel && !bus.reg_raddr[11]) begin
         if (r_in_range) begin
            if (data_wr && (w_idx == r_idx)) begin
               rsrc_next = SRC_HOLD;
               hold_next = bus.reg_wdata;
            end else begin
               rsrc_next = SRC_MEM;
            end
         end
      end else if (r_sel && (bus.reg_raddr[11:0] == CTRL_MASK)) begin
         rsrc_next = SRC_HOLD;
         hold_next = DATA_W'(clr_wr ? (valid_mask & ~bus.reg_wdata[NUM_BOARDS-1:0]) : valid_mask);
      end else if (r_sel && (bus.reg_raddr[11:0] == CTRL_SEQ)) begin
         rsrc_next = SRC_HOLD;
         hold_next = {8'h00, 8'(NUM_BOARDS), hub_seq};
      end
   end

   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         valid_mask <= '0;
         all_valid  <= 1'b0;
         hub_seq    <= '0;
         rsrc_q     <= SRC_ZERO;
         hold_q     <= '0;
      end else begin
         valid_mask <= mask_next;
         all_valid  <= &mask_next;
         hub_seq    <= hub_seq + 16'(hub_start);
         rsrc_q     <= rsrc_next;
         hold_q     <= hold_next;
      end
   end

   assign bus.reg_rdata = (rsrc_q == SRC_MEM)  ? mem_q  :
                          (rsrc_q == SRC_HOLD) ? hold_q : '0;
endmodule

// File: tb/tb_hub_reg_bank.sv
// Bench for hub_reg_bank (4 boards x 8 words, select nibble 2): directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a behavioural model.
module tb_hub_reg_bank;
   localparam int NB = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       hub_start;
   logic [3:0] valid_mask;
   logic       all_valid;
   int         checks = 0;
   int         errors = 0;

   hub_reg_bank_if bus ();

   hub_reg_bank #(
      .ADDR_SEL(4'h2), .NUM_BOARDS(NB), .WORDS_PER_BOARD(8), .DATA_W(32)
   ) dut (
      .sysclk(clk), .reset(rst_n), .bus(bus),
      .hub_start(hub_start), .valid_mask(valid_mask), .all_valid(all_valid)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   logic [31:0] m_mem [32];
   bit          m_known [32];
   logic [3:0]  m_mask = '0;
   logic [15:0] m_seq = '0;
   logic [31:0] exp_rdata = '0;
   bit          exp_known = 1'b1;

   function automatic bit is_data(input logic [15:0] a);
      return (a[15:12] == 4'h2) && !a[11];
   endfunction

   always @(negedge rst_n) begin
      m_mask    = '0;
      m_seq     = '0;
      exp_rdata = '0;
      exp_known = 1'b1;
   end

   always @(posedge clk) begin
      if (rst_n) begin
         logic [15:0] ra, wa;
         logic [31:0] wd;
         bit          wr, clr;
         ra  = bus.reg_raddr;
         wa  = bus.reg_waddr;
         wd  = bus.reg_wdata;
         wr  = bus.reg_wen;
         clr = wr && (wa[15:12] == 4'h2) && (wa[11:0] == 12'h800);
         // read result, judged from the state before this edge
         exp_known = 1'b1;
         exp_rdata = '0;
         if (is_data(ra)) begin
            if (wr && is_data(wa) && (wa[4:0] == ra[4:0])) exp_rdata = wd;
            else begin
               exp_rdata = m_mem[ra[4:0]];
               exp_known = m_known[ra[4:0]];
            end
         end else if (ra[15:12] == 4'h2 && ra[11:0] == 12'h800)
            exp_rdata = {28'd0, clr ? (m_mask & ~wd[3:0]) : m_mask};
         else if (ra[15:12] == 4'h2 && ra[11:0] == 12'h801)
            exp_rdata = {16'h0004, m_seq};
         // state updates
         if (hub_start) begin
            m_mask = '0;
            m_seq  = m_seq + 16'd1;
         end
         if (clr) m_mask = m_mask & ~wd[3:0];
         if (wr && is_data(wa)) begin
            m_mem[wa[4:0]]   = wd;
            m_known[wa[4:0]] = 1'b1;
            if (wa[2:0] == 3'd7) m_mask[wa[4:3]] = 1'b1;
         end
      end
   end

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (exp_known) check("rdata", bus.reg_rdata, exp_rdata);
         check("valid_mask", {28'd0, valid_mask}, {28'd0, m_mask});
         check("all_valid", {31'd0, all_valid}, {31'd0, (m_mask == 4'hF)});
      end
   end

   // ---------------- driver ----------------
   task automatic step(input logic wen, input logic [15:0] wa, input logic [31:0] wd,
                       input logic [15:0] ra, input logic hs);
      bus.reg_wen   = wen;
      bus.reg_waddr = wa;
      bus.reg_wdata = wd;
      bus.reg_raddr = ra;
      hub_start     = hs;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] rand_addr();
      logic [15:0] a;
      a[15:12] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h2;
      if ($urandom_range(0, 4) == 0) a[11:0] = 12'h800 + 12'($urandom_range(0, 3));
      else a[11:0] = {1'b0, 11'($urandom_range(0, 2047))};
      return a;
   endfunction

   logic [31:0] saved [6];

   initial begin
      bus.reg_wen = 1'b0; bus.reg_waddr = '0; bus.reg_wdata = '0; bus.reg_raddr = '0;
      hub_start = 1'b0;
      #1;
      check("reset_rdata", bus.reg_rdata, 32'h0);
      check("reset_mask", {28'd0, valid_mask}, 32'h0);
      check("reset_all_valid", {31'd0, all_valid}, 32'h0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // write then read back a data word
      step(1, 16'h200B, 32'hDEADBEEF, 16'h0000, 0);
      step(0, 16'h0000, 32'h0, 16'h200B, 0);
      check("rd_200B", bus.reg_rdata, 32'hDEADBEEF);
      check("mask_after_word3", {28'd0, valid_mask}, 32'h0);
      // last word completes board 2
      step(1, 16'h2017, 32'h00000055, 16'h0000, 0);
      check("mask_board2", {28'd0, valid_mask}, 32'h4);
      check("all_valid_partial", {31'd0, all_valid}, 32'h0);
      step(0, 16'h0000, 32'h0, 16'h2800, 0);
      check("rd_mask_reg", bus.reg_rdata, 32'h00000004);
      // complete everything, clear by write, then hub_start
      step(1, 16'h2007, 32'h1, 16'h0, 0);
      step(1, 16'h200F, 32'h2, 16'h0, 0);
      step(1, 16'h2017, 32'h3, 16'h0, 0);
      step(1, 16'h201F, 32'h4, 16'h0, 0);
      check("all_valid_full", {31'd0, all_valid}, 32'h1);
      step(1, 16'h2800, 32'h00000005, 16'h0, 0);
      check("mask_clear_write", {28'd0, valid_mask}, 32'hA);
      step(0, 16'h0, 32'h0, 16'h0, 1);
      check("mask_hub_start", {28'd0, valid_mask}, 32'h0);
      step(0, 16'h0, 32'h0, 16'h2801, 0);
      check("rd_seq_1", bus.reg_rdata, 32'h00040001);
      // read-during-write bypass, and hub_start together with a completion
      step(1, 16'h200B, 32'h12345678, 16'h200B, 0);
      check("bypass_data", bus.reg_rdata, 32'h12345678);
      step(1, 16'h201F, 32'h9, 16'h0, 1);
      check("hub_start_and_complete", {28'd0, valid_mask}, 32'h8);
      // unselected write and unmapped reads
      step(1, 16'h300B, 32'hCAFEF00D, 16'h0, 0);
      step(1, 16'h3017, 32'hCAFEF00D, 16'h0, 0);
      check("mask_unselected_wr", {28'd0, valid_mask}, 32'h8);
      step(0, 16'h0, 32'h0, 16'h200B, 0);
      check("mem_unselected_wr", bus.reg_rdata, 32'h12345678);
      step(0, 16'h0, 32'h0, 16'h2802, 0);
      check("rd_2802", bus.reg_rdata, 32'h0);
      step(0, 16'h0, 32'h0, 16'h300B, 0);
      check("rd_unselected", bus.reg_rdata, 32'h0);
      // bypass of the mask register through a clear-write
      step(1, 16'h2007, 32'h5, 16'h0, 0);
      step(1, 16'h200F, 32'h6, 16'h0, 0);
      step(1, 16'h2800, 32'h00000001, 16'h2800, 0);
      check("bypass_mask", bus.reg_rdata, 32'h0000000A);
      check("mask_after_bypass", {28'd0, valid_mask}, 32'hA);

      // hub_seq is 2 here; 65533 pulses reach 0xFFFF, one more wraps
      for (int i = 0; i < 65533; i++) step(0, 16'h0, 32'h0, 16'h0, 1);
      step(0, 16'h0, 32'h0, 16'h2801, 0);
      check("rd_seq_ffff", bus.reg_rdata, 32'h0004FFFF);
      step(0, 16'h0, 32'h0, 16'h0, 1);
      step(0, 16'h0, 32'h0, 16'h2801, 0);
      check("rd_seq_wrap", bus.reg_rdata, 32'h00040000);

      // randomized traffic, memory prefilled so every read is defined
      for (int i = 0; i < 32; i++) step(1, 16'h2000 + 16'(i), $urandom, 16'h0, 0);
      for (int i = 0; i < 1500; i++) begin
         logic [15:0] wa, ra;
         wa = rand_addr();
         ra = ($urandom_range(0, 3) == 0) ? wa : rand_addr();
         step(1'($urandom_range(0, 1)), wa, $urandom, ra, ($urandom_range(0, 19) == 0));
      end

      // asynchronous reset in the middle of a board burst
      step(1, 16'h2007, 32'h77, 16'h0, 0);
      for (int i = 0; i < 6; i++) begin
         saved[i] = $urandom | 32'h1;
         step(1, 16'h2018 + 16'(i), saved[i], 16'h0, 0);
      end
      step(0, 16'h0, 32'h0, 16'h2018, 0);
      #3 rst_n = 1'b0;
      #1;
      check("async_rst_rdata", bus.reg_rdata, 32'h0);
      check("async_rst_mask", {28'd0, valid_mask}, 32'h0);
      check("async_rst_all_valid", {31'd0, all_valid}, 32'h0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      step(0, 16'h0, 32'h0, 16'h2018, 0);
      check("mem_kept_2018", bus.reg_rdata, saved[0]);
      check("mask_after_reset", {28'd0, valid_mask}, 32'h0);
      step(0, 16'h0, 32'h0, 16'h201D, 0);
      check("mem_kept_201D", bus.reg_rdata, saved[5]);
      step(0, 16'h0, 32'h0, 16'h2801, 0);
      check("seq_after_reset", bus.reg_rdata, 32'h00040000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/hub_reg_bank.md
# hub_reg_bank

Parametrised hub register bank for the broadcast/hub read path. It holds one block of DATA_W-bit words per board and is written by the sysclk write port when a board's feedback arrives. Per board it tracks a "valid" flag that is set when the board's last word lands. It exposes a control/status region (valid mask, hub sequence) and gives the host a one-cycle registered read port with read-during-write bypass.

## Interface
Parameters:
- ADDR_SEL, default `ADDR_HUB (Constants.v): value of addr[15:12] that selects this block.
- NUM_BOARDS, default 16: board slots, 1..32.
- WORDS_PER_BOARD, default 16: words per board, power of two, ≥2.
- DATA_W, default 32: word width, fixed at 32 for host compatibility.
- Derived parameters:
  - WW = log2(WORDS_PER_BOARD).
  - BW = max(1, ceil(log2(NUM_BOARDS))).
  - WW+BW ≤ 11.

Ports:
- sysclk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low; clears all state registers.
- reg_wen  in  1  write strobe, one cycle per word.
- reg_waddr  in  16  write address.
- reg_wdata  in  32  write data.
- reg_raddr  in  16  read address, sampled every cycle.
- reg_rdata  out  32  registered read data.
- hub_start  in  1  single-cycle pulse marking the start of a new hub cycle.
- valid_mask  out  NUM_BOARDS  bit b = board b complete since last clear.
- all_valid  out  1  registered AND of valid_mask.

## Operation
- Selection: sel = (addr[15:12] == ADDR_SEL). Data region: addr[11] = 0. Control region: addr[11] = 1.
- Data address fields: word = addr[WW-1:0], board = addr[WW+BW-1:WW]. Bits addr[10:WW+BW] are ignored.
- Data write: reg_wen & sel & ~addr[11] & board < NUM_BOARDS writes the word into memory. Storage is NUM_BOARDS*WORDS_PER_BOARD words, inferred block RAM.
  - Memory is not reset; unwritten locations read undefined.
- Completion: a data write with word == WORDS_PER_BOARD-1 sets valid_mask[board].
- Clear by write: reg_wen & sel & addr[11:0] == 0x800 clears each valid_mask[b] where reg_wdata[b] = 1.
- hub_start:
  - Clears all valid_mask bits.
  - Increments hub_seq, 16 bits, wrapping 0xFFFF→0x0000.
- Simultaneous hub_start and completion: the clear applies first, then the set, so the completing board ends valid.
- Read decode (sel & addr[11:0]):
  - Data region, board < NUM_BOARDS: memory word.
  - Data region, board ≥ NUM_BOARDS: 0.
  - 0x800: valid_mask, zero-extended.
  - 0x801: {8'h00, NUM_BOARDS[7:0], hub_seq[15:0]}.
  - Other control addresses, or ~sel: 0.
- Writes to unselected, out-of-range or read-only addresses have no effect.

## Timing
- Reset values:
  - reg_rdata = 0, valid_mask = 0, all_valid = 0, hub_seq = 0.
  - Reset takes effect asynchronously; release is synchronous to sysclk.
- Read latency is 1 cycle: reg_raddr sampled at edge N appears on reg_rdata after edge N.
- Read-during-write bypass:
  - Same-cycle data write to the read address returns the new reg_wdata.
  - Same-cycle write to 0x800 returns the post-clear mask.
- valid_mask, all_valid and hub_seq update on the edge that samples the causing write or hub_start. A read of 0x800/0x801 in the following cycle sees the new value.
- Back-to-back writes: one per cycle, no stall, no ready signal.
- Reset asserted mid-burst: partially written board stays invalid; memory contents retained.
- hub_start held high for k cycles counts as k increments; the driver guarantees single-cycle pulses.

## Test plan
Configuration for all scenarios: NUM_BOARDS=4, WORDS_PER_BOARD=8, ADDR_SEL=4'h2.
- Write 0x200B=0xDEADBEEF (board 1, word 3), then read 0x200B -> reg_rdata=0xDEADBEEF one cycle after the read address; valid_mask stays 4'b0000.
- Write 0x2017=0x00000055 (board 2, word 7) -> valid_mask=4'b0100 next cycle; all_valid=0; read 0x2800 -> 0x00000004.
- Complete boards 0..3, then write 0x2800=0x00000005 -> valid_mask=4'b1010.
  - Pulse hub_start -> valid_mask=0.
  - Read 0x2801 -> 0x00040001.
- Same-cycle write 0x200B=0x12345678 and read 0x200B -> 0x12345678 next cycle.
  - hub_start in the same cycle as a write to 0x201F -> valid_mask=4'b1000.
- Write with addr[15:12]=4'h3 -> memory and mask unchanged.
  - Read 0x2802 -> 0.
  - Read with addr[15:12]=4'h3 -> 0.
  - 65536 hub_start pulses -> hub_seq wraps to 0x0000.
- Assert reset asynchronously mid-cycle after writing words 0..5 of board 3:
  - Outputs go to 0 before the next edge.
  - After release, read 0x2018 returns the pre-reset data.
  - valid_mask = 0.
